pixel_write_responder: RTL and testbench
========================================

# pixel_write_responder

Memory-side responder for the solver write port: accepts pixel writes (16-bit iteration value + 32-bit pixel address) with a one-cycle ack handshake, buffers them in a FIFO, and issues them as byte-addressed Avalon-MM master writes to the frame buffer SDRAM. It sits between the solver array's write output and the SDRAM controller. It absorbs memory stalls so the solvers keep producing pixels.

## Interface
- FIFO_DEPTH_BITS, 3, log2 of FIFO entries (8 by default)
- BASE_ADDR, 32'h0000_0000, byte address of pixel 0 in the frame buffer
- clock  input  1  single clock; all logic is rising-edge
- reset  input  1  asynchronous, active-low (asserted at 0); takes effect immediately and releases on a clock edge
- in_data  input  16  pixel value to write
- in_addr  input  32  pixel index (not byte address)
- in_write_en  input  1  write request pending; held with data/addr until acked
- in_ack  output  1  one-cycle acceptance of the presented write
- mem_address  output  32  byte address
- mem_writedata  output  16  pixel value
- mem_write  output  1  Avalon write request
- mem_waitrequest  input  1  Avalon stall
- write_count  output  32  completed memory writes, wraps at 2^32
- idle  output  1  FIFO empty and no memory write outstanding

## Operation
- Upstream handshake: `in_ack = in_write_en & ~fifo_full`, combinational. A write is accepted in the cycle with in_write_en=1 and in_ack=1. in_write_en=1 in the following cycle is a new transaction. in_ack is never 1 while in_write_en=0.
- Full check uses the registered count only. A pop in the same cycle does not free a slot for a push in that cycle.
- On acceptance, push {in_data, BASE_ADDR + (in_addr << 1)} into the FIFO.
  - Compute the address in 33 bits and truncate to 32; it wraps modulo 2^32.
  - in_addr[31] is discarded by the shift.
- FIFO: 2^FIFO_DEPTH_BITS entries, circular read/write pointers wrapping to 0. The occupancy counter is FIFO_DEPTH_BITS+1 bits wide, so full is count == 2^FIFO_DEPTH_BITS.
- Output stage: one register slot driving mem_address/mem_writedata/mem_write.
  - States: EMPTY (mem_write=0) and BUSY (mem_write=1).
  - EMPTY -> BUSY when FIFO non-empty; pop the head into the slot.
  - BUSY with mem_waitrequest=1: hold address/data/mem_write unchanged.
  - BUSY with mem_waitrequest=0: write completes and write_count increments by 1. If the FIFO is non-empty, pop the next entry and stay BUSY (back-to-back writes). Otherwise go to EMPTY.
- Total buffering = 2^FIFO_DEPTH_BITS + 1 writes.
- In-order: memory writes are issued in exactly acceptance order. No coalescing and no drops.
- `idle = (count == 0) & ~mem_write`, registered-state-derived.
- Reset:
  - in_ack=0 (in_write_en forced low is not required; ack is gated by reset).
  - mem_write=0, mem_address=0, mem_writedata=0.
  - write_count=0, idle=1, FIFO pointers/count=0.
  - Reset mid-operation discards all buffered and in-flight writes. No partial Avalon transaction is completed.

## Timing
- Accept at cycle N -> entry in FIFO after edge N. Output slot loads after edge N+1. mem_write=1 in cycle N+2 (2-cycle latency when the output stage is idle).
- With mem_waitrequest=0 continuously, sustained throughput is 1 write/cycle. in_ack stays high every cycle while in_write_en=1.
- FIFO full: in_ack=0 until the first pop edge. in_ack returns in the cycle after that pop.
- write_count updates on the edge ending the completing cycle.
- The mem_* outputs change only on EMPTY->BUSY, on a completing edge, or on reset. They are stable throughout any waitrequest stall.

## Test plan
- Single write: in_addr=5, in_data=16'h00AB, BASE_ADDR=32'h1000_0000, waitrequest=0.
  - Expect in_ack same cycle, then mem_write 2 cycles later with mem_address=32'h1000_000A and writedata=16'h00AB.
  - Then write_count=1 and idle=1.
- Burst of 20 writes with addresses 0..19 and waitrequest=0.
  - Expect 20 in_ack pulses on consecutive cycles and 20 consecutive mem_write cycles.
  - Addresses BASE..BASE+38 in order; write_count=20.
- Backpressure: waitrequest=1 held while 12 writes are offered (FIFO_DEPTH_BITS=3).
  - Exactly 9 writes are acked (8 FIFO + 1 slot); in_ack=0 afterward, and mem_* stay stable.
  - Release waitrequest: the remaining 3 writes are acked, all 12 complete in order.
- Wrap-around: BASE_ADDR=32'hFFFF_FFF0 and in_addr=32'h8000_0010.
  - mem_address=32'h0000_0010; pointer wrap verified over 3×8 writes with no reordering.
- Async reset asserted mid-burst (4 buffered, 1 stalled in slot):
  - Outputs drop to 0 immediately, idle=1, write_count=0.
  - After release, a new write completes with correct latency and no stale writes appear.

Source files
------------

// File: rtl/pixel_write_responder_if.sv
// Pixel write handshake from the solver array plus the Avalon-MM write port
// toward the frame buffer SDRAM controller.
interface pixel_write_responder_if;
  logic [15:0] in_data;
  logic [31:0] in_addr;
  logic        in_write_en;
  logic        in_ack;
  logic [31:0] mem_address;
  logic [15:0] mem_writedata;
  logic        mem_write;
  logic        mem_waitrequest;

  modport slave (
    input  in_data, in_addr, in_write_en, mem_waitrequest,
    output in_ack, mem_address, mem_writedata, mem_write
  );

  modport master (
    output in_data, in_addr, in_write_en, mem_waitrequest,
    input  in_ack, mem_address, mem_writedata, mem_write
  );
endinterface

// File: rtl/pixel_write_responder.sv
// Buffers accepted pixel writes in a FIFO and replays them in order as
// byte-addressed Avalon-MM writes, absorbing SDRAM stalls.
//
// state    | meaning
// ST_EMPTY | output slot free, mem_write low
// ST_BUSY  | slot holds a write, mem_write high until waitrequest drops
module pixel_write_responder #(
  parameter int          FIFO_DEPTH_BITS = 3,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
  input  logic                          clock,
  input  logic                          reset,
  pixel_write_responder_if.slave        bus,
  output logic [31:0]                   write_count,
  output logic                          idle
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT = (FIFO_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_BUSY  = 1'b1;

  logic [15:0]                data_mem [DEPTH];
  logic [31:0]                addr_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   count;
  logic [0:0]                 state;
  logic [31:0]                mem_address_q;
  logic [15:0]                mem_writedata_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        complete;
  logic [32:0] addr_sum;
  logic [31:0] push_addr;
  logic        unused_carry;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);

  // Reset gates the ack so nothing is accepted while the FIFO is being cleared.
  assign bus.in_ack = bus.in_write_en & ~fifo_full & reset;
  assign push       = bus.in_ack;
  assign complete   = (state == ST_BUSY) & ~bus.mem_waitrequest;
  assign pop        = ~fifo_empty & ((state == ST_EMPTY) | complete);

  // Pixel index to byte address; the carry out of bit 31 is dropped.
  assign addr_sum     = {1'b0, BASE_ADDR} + {bus.in_addr, 1'b0};
  assign push_addr    = addr_sum[31:0];
  assign unused_carry = addr_sum[32];

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.in_data;
      addr_mem[wr_ptr] <= push_addr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= ST_EMPTY;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      write_count     <= '0;
    end else begin
      if (complete) write_count <= write_count + 1'b1;
      if (pop) begin
        state           <= ST_BUSY;
        mem_address_q   <= addr_mem[rd_ptr];
        mem_writedata_q <= data_mem[rd_ptr];
      end else if (complete) begin
        state <= ST_EMPTY;
      end
    end
  end

  assign bus.mem_write     = (state == ST_BUSY);
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;
  assign idle              = fifo_empty & (state == ST_EMPTY);

endmodule

// File: tb/tb_pixel_write_responder.sv
// Directed bench: two responders (normal base and wrapping base) share clock/reset.
module tb_pixel_write_responder;
  logic        clock;
  logic        reset;
  logic [31:0] wc_a, wc_b;
  logic        idle_a, idle_b;
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;

  logic [31:0] qa_addr[$];
  logic [15:0] qa_data[$];
  int          qa_cyc[$];
  logic [31:0] qb_addr[$];
  logic [15:0] qb_data[$];

  pixel_write_responder_if ifa ();
  pixel_write_responder_if ifb ();

  pixel_write_responder #(.FIFO_DEPTH_BITS(3), .BASE_ADDR(32'h1000_0000)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa.slave), .write_count(wc_a), .idle(idle_a));
  pixel_write_responder #(.FIFO_DEPTH_BITS(3), .BASE_ADDR(32'hFFFF_FFF0)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb.slave), .write_count(wc_b), .idle(idle_b));

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cycle <= cycle + 1;

  // A write completes at the next edge whenever mem_write is high without stall.
  always @(negedge clock) begin
    if (ifa.mem_write && !ifa.mem_waitrequest) begin
      qa_addr.push_back(ifa.mem_address);
      qa_data.push_back(ifa.mem_writedata);
      qa_cyc.push_back(cycle);
    end
    if (ifb.mem_write && !ifb.mem_waitrequest) begin
      qb_addr.push_back(ifb.mem_address);
      qb_data.push_back(ifb.mem_writedata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    @(negedge clock);
    while (!idle_a && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk(tag, {31'd0, idle_a}, 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic wait_idle_b(input string tag);
    int n = 0;
    @(negedge clock);
    while (!idle_b && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk(tag, {31'd0, idle_b}, 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    int          idx;
    int          n_ack;
    logic [31:0] exp_addr;

    reset = 0;
    ifa.in_data = '0; ifa.in_addr = '0; ifa.in_write_en = 1'b1; ifa.mem_waitrequest = 1'b0;
    ifb.in_data = '0; ifb.in_addr = '0; ifb.in_write_en = 1'b0; ifb.mem_waitrequest = 1'b0;

    // Reset state, with a write request held to show ack is gated.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ack", {31'd0, ifa.in_ack}, 32'd0);
    chk("rst_mem_write", {31'd0, ifa.mem_write}, 32'd0);
    chk("rst_mem_address", ifa.mem_address, 32'd0);
    chk("rst_mem_writedata", {16'd0, ifa.mem_writedata}, 32'd0);
    chk("rst_write_count", wc_a, 32'd0);
    chk("rst_idle", {31'd0, idle_a}, 32'd1);
    @(posedge clock); #1;
    ifa.in_write_en = 1'b0;
    reset = 1;
    @(posedge clock); #1;

    // Single write: pixel 5 -> 0x1000_000A, visible two cycles after accept.
    ifa.in_addr = 32'd5; ifa.in_data = 16'h00AB; ifa.in_write_en = 1'b1;
    @(negedge clock);
    chk("single_ack", {31'd0, ifa.in_ack}, 32'd1);
    @(posedge clock); #1;
    ifa.in_write_en = 1'b0;
    @(negedge clock);
    chk("single_lat1_write", {31'd0, ifa.mem_write}, 32'd0);
    @(posedge clock); @(negedge clock);
    chk("single_lat2_write", {31'd0, ifa.mem_write}, 32'd1);
    chk("single_address", ifa.mem_address, 32'h1000_000A);
    chk("single_data", {16'd0, ifa.mem_writedata}, 32'h0000_00AB);
    @(posedge clock); @(negedge clock);
    chk("single_count", wc_a, 32'd1);
    chk("single_idle", {31'd0, idle_a}, 32'd1);
    @(posedge clock); #1;

    // Burst of 20 with no stall: one ack and one write per cycle.
    qa_addr.delete(); qa_data.delete(); qa_cyc.delete();
    n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      ifa.in_addr = i; ifa.in_data = 16'(16'h0100 + i); ifa.in_write_en = 1'b1;
      @(negedge clock);
      if (ifa.in_ack) n_ack++;
      @(posedge clock); #1;
    end
    ifa.in_write_en = 1'b0;
    chk("burst_acks", n_ack, 32'd20);
    wait_idle_a("burst_idle");
    chk("burst_writes", qa_addr.size(), 32'd20);
    if (qa_addr.size() == 20) begin
      chk("burst_consecutive", qa_cyc[19] - qa_cyc[0], 32'd19);
      for (int i = 0; i < 20; i++) begin
        chk("burst_addr", qa_addr[i], 32'h1000_0000 + 32'(2 * i));
        chk("burst_data", {16'd0, qa_data[i]}, 32'h0100 + 32'(i));
      end
    end
    chk("burst_count", wc_a, 32'd21);

    // Backpressure: 12 offered under a held stall, only 9 fit.
    qa_addr.delete(); qa_data.delete(); qa_cyc.delete();
    ifa.mem_waitrequest = 1'b1;
    idx = 0;
    for (int c = 0; c < 15; c++) begin
      ifa.in_addr = 32'(100 + idx); ifa.in_data = 16'(16'h0200 + idx);
      ifa.in_write_en = (idx < 12);
      @(negedge clock);
      if (ifa.in_write_en && ifa.in_ack) idx++;
      @(posedge clock); #1;
    end
    chk("bp_acked", idx, 32'd9);
    ifa.in_addr = 32'(100 + idx); ifa.in_data = 16'(16'h0200 + idx); ifa.in_write_en = 1'b1;
    @(negedge clock);
    chk("bp_full_ack", {31'd0, ifa.in_ack}, 32'd0);
    chk("bp_hold_write", {31'd0, ifa.mem_write}, 32'd1);
    chk("bp_hold_address", ifa.mem_address, 32'h1000_00C8);
    chk("bp_hold_data", {16'd0, ifa.mem_writedata}, 32'h0000_0200);
    @(posedge clock); #1;
    ifa.mem_waitrequest = 1'b0;
    @(negedge clock);
    chk("bp_release_ack_same", {31'd0, ifa.in_ack}, 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp_release_ack_next", {31'd0, ifa.in_ack}, 32'd1);
    if (ifa.in_ack) idx++;
    @(posedge clock); #1;
    for (int c = 0; c < 20 && idx < 12; c++) begin
      ifa.in_addr = 32'(100 + idx); ifa.in_data = 16'(16'h0200 + idx); ifa.in_write_en = 1'b1;
      @(negedge clock);
      if (ifa.in_ack) idx++;
      @(posedge clock); #1;
    end
    ifa.in_write_en = 1'b0;
    chk("bp_total_acked", idx, 32'd12);
    wait_idle_a("bp_idle");
    chk("bp_writes", qa_addr.size(), 32'd12);
    if (qa_addr.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        chk("bp_addr", qa_addr[i], 32'h1000_0000 + 32'(2 * (100 + i)));
        chk("bp_data", {16'd0, qa_data[i]}, 32'h0200 + 32'(i));
      end
    end
    chk("bp_count", wc_a, 32'd33);

    // Address wrap on the second instance: 0xFFFF_FFF0 + (0x8000_0010 << 1).
    ifb.in_addr = 32'h8000_0010; ifb.in_data = 16'h1234; ifb.in_write_en = 1'b1;
    @(negedge clock);
    chk("wrap_ack", {31'd0, ifb.in_ack}, 32'd1);
    @(posedge clock); #1;
    ifb.in_write_en = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("wrap_write", {31'd0, ifb.mem_write}, 32'd1);
    chk("wrap_address", ifb.mem_address, 32'h0000_0010);
    chk("wrap_data", {16'd0, ifb.mem_writedata}, 32'h0000_1234);
    wait_idle_b("wrap_idle");

    // 24 writes, stalled at first so the FIFO fills and pointers wrap while occupied.
    qb_addr.delete(); qb_data.delete();
    idx = 0;
    for (int c = 0; c < 200 && idx < 24; c++) begin
      ifb.mem_waitrequest = (c < 12);
      ifb.in_addr = idx; ifb.in_data = 16'(16'h0300 + idx); ifb.in_write_en = 1'b1;
      @(negedge clock);
      if (ifb.in_ack) idx++;
      @(posedge clock); #1;
    end
    ifb.in_write_en = 1'b0;
    ifb.mem_waitrequest = 1'b0;
    chk("wrap_acked", idx, 32'd24);
    wait_idle_b("wrap_burst_idle");
    chk("wrap_writes", qb_addr.size(), 32'd24);
    if (qb_addr.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        exp_addr = 32'hFFFF_FFF0 + 32'(2 * i);
        chk("wrap_burst_addr", qb_addr[i], exp_addr);
        chk("wrap_burst_data", {16'd0, qb_data[i]}, 32'h0300 + 32'(i));
      end
    end
    chk("wrap_count", wc_b, 32'd25);

    // Async reset with one write stalled in the slot and four buffered.
    ifa.mem_waitrequest = 1'b1;
    idx = 0;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      ifa.in_addr = 32'(50 + idx); ifa.in_data = 16'(16'h0400 + idx); ifa.in_write_en = 1'b1;
      @(negedge clock);
      if (ifa.in_ack) idx++;
      @(posedge clock); #1;
    end
    ifa.in_write_en = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("mid_acked", idx, 32'd5);
    chk("mid_write_before", {31'd0, ifa.mem_write}, 32'd1);
    #1;
    reset = 0;
    #1;
    chk("arst_write", {31'd0, ifa.mem_write}, 32'd0);
    chk("arst_address", ifa.mem_address, 32'd0);
    chk("arst_data", {16'd0, ifa.mem_writedata}, 32'd0);
    chk("arst_count", wc_a, 32'd0);
    chk("arst_idle", {31'd0, idle_a}, 32'd1);
    ifa.mem_waitrequest = 1'b0;
    @(posedge clock); #1;
    qa_addr.delete(); qa_data.delete(); qa_cyc.delete();
    reset = 1;
    @(posedge clock); #1;
    ifa.in_addr = 32'd7; ifa.in_data = 16'h0077; ifa.in_write_en = 1'b1;
    @(negedge clock);
    chk("post_ack", {31'd0, ifa.in_ack}, 32'd1);
    @(posedge clock); #1;
    ifa.in_write_en = 1'b0;
    @(negedge clock);
    chk("post_lat1_write", {31'd0, ifa.mem_write}, 32'd0);
    @(posedge clock); @(negedge clock);
    chk("post_lat2_write", {31'd0, ifa.mem_write}, 32'd1);
    chk("post_address", ifa.mem_address, 32'h1000_000E);
    chk("post_data", {16'd0, ifa.mem_writedata}, 32'h0000_0077);
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("post_writes", qa_addr.size(), 32'd1);
    chk("post_count", wc_a, 32'd1);
    chk("post_idle", {31'd0, idle_a}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
